execute_stage: RTL and testbench
================================

Name: execute_stage

Overview:
- Execute (EX) stage of the team's 64-bit LEGv8-style pipelined datapath.
- Selects the ALU B operand (register or sign-extended immediate) and performs the ALU operation.
- Computes the branch target PC_E + (signImm_E << 2) and forwards readData2_E as store data.
- All results are captured in an EX/MEM output register, one cycle after the inputs.

Parameters:
- N, 64, datapath width for PC, immediate, operands and results.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- AluSrc  in  1  ALU B select: 0 = readData2_E, 1 = signImm_E
- AluControl  in  4  ALU operation code
- PC_E  in  N  PC of the instruction in EX
- signImm_E  in  N  sign-extended immediate, in words (not yet shifted)
- readData1_E  in  N  register operand A
- readData2_E  in  N  register operand B / store data
- PCBranch_E  out  N  registered branch target
- aluResult_E  out  N  registered ALU result
- writeData_E  out  N  registered copy of readData2_E
- zero_E  out  1  registered flag: ALU result == 0

Behaviour:
- Combinational core:
  - B = AluSrc ? signImm_E : readData2_E.
  - AluControl 0000: A & B.
  - AluControl 0001: A | B.
  - AluControl 0010: A + B.
  - AluControl 0110: A - B.
  - AluControl 0111: pass B.
  - Any other code: result 0.
- Arithmetic is unsigned modulo 2^N. No carry, overflow or exception outputs. Subtraction wraps, e.g. 0 - 1 = all ones.
- Branch target = PC_E + (signImm_E << 2), modulo 2^N. Bits shifted out of the MSB are lost. A negative immediate yields a backward target.
- zero = (ALU result == 0). Evaluated on the actual result, including undefined codes (which give zero = 1).
- writeData = readData2_E unchanged, regardless of AluSrc.
- Register stage:
  - On each rising clk, all four outputs load the combinational values.
  - Latency is exactly 1 cycle. No enable, no stall, no handshake.
- Reset:
  - reset=1 at a rising edge clears PCBranch_E, aluResult_E and writeData_E to 0, and zero_E to 0.
  - reset has priority over data capture, including when asserted mid-stream.
  - The first capture after reset deasserts reflects the inputs at that edge.
- Outputs change only at clock edges. No combinational path from inputs to outputs.

Decomposition:
- Shared package (e.g. legv8_pkg):
  - ALU opcode constants ALU_AND=4'b0000, ALU_OR=4'b0001, ALU_ADD=4'b0010, ALU_SUB=4'b0110, ALU_PASSB=4'b0111.
  - Default width N=64.
- One sub-module, alu:
  - Purely combinational.
  - Ports a, b, ALUControl, result, zero.
  - Parameterized by N.
- execute_stage contains:
  - the B-operand mux;
  - the shift-by-2 and branch adder;
  - the output register.

Test Plan:
- AluSrc=0, AND, PC=0, imm=0, rd1=0, rd2=4 -> next cycle: PCBranch=0x0, aluResult=0x0, writeData=0x4, zero=1.
- AluSrc=1, OR, PC=0xC, imm=0xC, rd1=0xC, rd2=0x0 -> PCBranch=0x3C, aluResult=0xC, writeData=0x0, zero=0.
- ADD:
  - AluSrc=0, rd1=0x10, rd2=0x14, PC=imm=0x10 -> PCBranch=0x50, result=0x24.
  - AluSrc=1, rd1=imm=PC=0x58, rd2=0x50 -> PCBranch=0x1B8, result=0xB0, writeData=0x50.
- SUB:
  - AluSrc=0, rd1=0x5C, rd2=0x54 -> result=0x8, zero=0.
  - AluSrc=1, rd1=imm=0x60 -> result=0, zero=1, PCBranch=0x1E0.
  - rd1=0, rd2=1 -> result=0xFFFF_FFFF_FFFF_FFFF.
- PASSB:
  - AluSrc=0, rd2=0x6C -> result=0x6C.
  - AluSrc=1, imm=0x68, rd2=0x60 -> result=0x68, PCBranch=0x208, writeData=0x60.
  - Undefined code 4'b1111 -> result=0, zero=1.
- Reset and sequencing:
  - Assert reset while valid inputs are applied -> all outputs 0 after the edge.
  - Deassert reset -> values appear one edge later.
  - Branch wrap: PC=0xFFFF_FFFF_FFFF_FFFC, imm=1 -> PCBranch=0x0.

Source files
------------

// File: rtl/execute_stage_pkg.sv
// -----------------------------------------------------------------------------
// execute_stage_pkg
// Shared definitions for the LEGv8-style execute stage: the default datapath
// width and the ALU operation encodings used on AluControl / ALUControl.
// -----------------------------------------------------------------------------
package execute_stage_pkg;

  localparam int unsigned N_DEFAULT = 64;

  typedef enum logic [3:0] {
    ALU_AND   = 4'b0000,
    ALU_OR    = 4'b0001,
    ALU_ADD   = 4'b0010,
    ALU_SUB   = 4'b0110,
    ALU_PASSB = 4'b0111
  } alu_op_e;

endpackage : execute_stage_pkg

// File: rtl/execute_stage_alu.sv
// -----------------------------------------------------------------------------
// alu
// Purely combinational N-bit ALU.
// Ports:
//   a, b        operands
//   ALUControl  operation code (see execute_stage_pkg::alu_op_e)
//   result      operation result, unsigned modulo 2^N; 0 for unknown codes
//   zero        1 when result == 0
// -----------------------------------------------------------------------------
module alu
  import execute_stage_pkg::*;
#(
  parameter int unsigned N = N_DEFAULT
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic [3:0]   ALUControl,
  output logic [N-1:0] result,
  output logic         zero
);

  always_comb begin
    result = '0;
    case (ALUControl)
      ALU_AND:   result = a & b;
      ALU_OR:    result = a | b;
      ALU_ADD:   result = a + b;
      ALU_SUB:   result = a - b;
      ALU_PASSB: result = b;
      default:   result = '0;
    endcase
  end

  // Derived from the actual result, so undefined codes also report zero.
  assign zero = (result == '0);

endmodule : alu

// File: rtl/execute_stage.sv
// -----------------------------------------------------------------------------
// execute_stage
// EX stage of the 64-bit LEGv8-style pipeline. Selects the ALU B operand,
// runs the ALU, computes the branch target and captures everything in the
// EX/MEM register one cycle after the inputs.
// Ports:
//   clk, reset    rising-edge clock, synchronous active-high reset
//   AluSrc        B select: 0 = readData2_E, 1 = signImm_E
//   AluControl    ALU operation code
//   PC_E          PC of the instruction in EX
//   signImm_E     sign-extended immediate in words
//   readData1_E   operand A
//   readData2_E   operand B / store data
//   PCBranch_E    registered PC_E + (signImm_E << 2)
//   aluResult_E   registered ALU result
//   writeData_E   registered readData2_E
//   zero_E        registered ALU zero flag
// -----------------------------------------------------------------------------
module execute_stage
  import execute_stage_pkg::*;
#(
  parameter int unsigned N = N_DEFAULT
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         AluSrc,
  input  logic [3:0]   AluControl,
  input  logic [N-1:0] PC_E,
  input  logic [N-1:0] signImm_E,
  input  logic [N-1:0] readData1_E,
  input  logic [N-1:0] readData2_E,
  output logic [N-1:0] PCBranch_E,
  output logic [N-1:0] aluResult_E,
  output logic [N-1:0] writeData_E,
  output logic         zero_E
);

  logic [N-1:0] alu_b;
  logic [N-1:0] pcbranch_d, pcbranch_q;
  logic [N-1:0] aluresult_d, aluresult_q;
  logic [N-1:0] writedata_d, writedata_q;
  logic         zero_d, zero_q;

  assign alu_b = AluSrc ? signImm_E : readData2_E;

  alu #(.N(N)) u_alu (
    .a          (readData1_E),
    .b          (alu_b),
    .ALUControl (AluControl),
    .result     (aluresult_d),
    .zero       (zero_d)
  );

  // Word offset to byte offset; bits shifted past the MSB are dropped.
  assign pcbranch_d  = PC_E + {signImm_E[N-3:0], 2'b00};
  assign writedata_d = readData2_E;

  always_ff @(posedge clk) begin
    if (reset) begin
      pcbranch_q  <= '0;
      aluresult_q <= '0;
      writedata_q <= '0;
      zero_q      <= 1'b0;
    end else begin
      pcbranch_q  <= pcbranch_d;
      aluresult_q <= aluresult_d;
      writedata_q <= writedata_d;
      zero_q      <= zero_d;
    end
  end

  assign PCBranch_E  = pcbranch_q;
  assign aluResult_E = aluresult_q;
  assign writeData_E = writedata_q;
  assign zero_E      = zero_q;

endmodule : execute_stage

// File: tb/tb_execute_stage.sv
// -----------------------------------------------------------------------------
// tb_execute_stage
// Scoreboard bench for execute_stage: each driven vector pushes its expected
// EX/MEM contents; one edge later the entry is popped and compared.
// -----------------------------------------------------------------------------
module tb_execute_stage;

  localparam int unsigned N = 64;

  logic         clk = 1'b0;
  logic         reset;
  logic         AluSrc;
  logic [3:0]   AluControl;
  logic [N-1:0] PC_E, signImm_E, readData1_E, readData2_E;
  logic [N-1:0] PCBranch_E, aluResult_E, writeData_E;
  logic         zero_E;

  typedef struct {
    string        tag;
    logic [N-1:0] pcb;
    logic [N-1:0] res;
    logic [N-1:0] wd;
    logic         z;
  } exp_t;

  exp_t exp_q[$];

  int n_asserts = 0;
  int n_fail    = 0;

  execute_stage #(.N(N)) dut (
    .clk         (clk),
    .reset       (reset),
    .AluSrc      (AluSrc),
    .AluControl  (AluControl),
    .PC_E        (PC_E),
    .signImm_E   (signImm_E),
    .readData1_E (readData1_E),
    .readData2_E (readData2_E),
    .PCBranch_E  (PCBranch_E),
    .aluResult_E (aluResult_E),
    .writeData_E (writeData_E),
    .zero_E      (zero_E)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [N-1:0] got, input logic [N-1:0] exp);
    n_asserts++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model of the stage, written from the operation table.
  function automatic exp_t model(input string tag, input logic rst, input logic src,
                                 input logic [3:0] ctl, input logic [N-1:0] pc,
                                 input logic [N-1:0] imm, input logic [N-1:0] a,
                                 input logic [N-1:0] rd2);
    exp_t e;
    logic [N-1:0] b;
    e.tag = tag;
    b = src ? imm : rd2;
    case (ctl)
      4'b0000: e.res = a & b;
      4'b0001: e.res = a | b;
      4'b0010: e.res = a + b;
      4'b0110: e.res = a - b;
      4'b0111: e.res = b;
      default: e.res = 64'd0;
    endcase
    e.pcb = pc + imm * 64'd4;
    e.wd  = rd2;
    e.z   = (e.res == 64'd0);
    if (rst) begin
      e.pcb = 64'd0; e.res = 64'd0; e.wd = 64'd0; e.z = 1'b0;
    end
    return e;
  endfunction

  task automatic pop_and_compare();
    exp_t e;
    if (exp_q.size() == 0) begin
      check("scoreboard_empty", 64'd0, 64'd1);
      return;
    end
    e = exp_q.pop_front();
    check({e.tag, ".pcbranch"}, PCBranch_E,  e.pcb);
    check({e.tag, ".result"},   aluResult_E, e.res);
    check({e.tag, ".wdata"},    writeData_E, e.wd);
    check({e.tag, ".zero"},     {63'd0, zero_E}, {63'd0, e.z});
  endtask

  // Drive one vector just after an edge, then compare one edge later.
  task automatic step(input string tag, input logic rst, input logic src,
                      input logic [3:0] ctl, input logic [N-1:0] pc,
                      input logic [N-1:0] imm, input logic [N-1:0] a,
                      input logic [N-1:0] rd2);
    reset = rst; AluSrc = src; AluControl = ctl;
    PC_E = pc; signImm_E = imm; readData1_E = a; readData2_E = rd2;
    exp_q.push_back(model(tag, rst, src, ctl, pc, imm, a, rd2));
    @(posedge clk); #1;
    pop_and_compare();
  endtask

  initial begin
    logic [N-1:0] held;
    reset = 1'b1; AluSrc = 1'b0; AluControl = 4'b0010;
    PC_E = 64'h1234; signImm_E = 64'h5; readData1_E = 64'h77; readData2_E = 64'h99;
    @(posedge clk); #1;
    step("reset_init", 1'b1, 1'b1, 4'b0010, 64'h40, 64'h3, 64'h11, 64'h22);

    step("and0",   1'b0, 1'b0, 4'b0000, 64'h0,  64'h0,  64'h0,  64'h4);
    step("or",     1'b0, 1'b1, 4'b0001, 64'hC,  64'hC,  64'hC,  64'h0);
    step("add_r",  1'b0, 1'b0, 4'b0010, 64'h10, 64'h10, 64'h10, 64'h14);
    step("add_i",  1'b0, 1'b1, 4'b0010, 64'h58, 64'h58, 64'h58, 64'h50);
    step("sub_r",  1'b0, 1'b0, 4'b0110, 64'h0,  64'h0,  64'h5C, 64'h54);
    step("sub_i0", 1'b0, 1'b1, 4'b0110, 64'h60, 64'h60, 64'h60, 64'h0);
    step("sub_wr", 1'b0, 1'b0, 4'b0110, 64'h0,  64'h0,  64'h0,  64'h1);
    step("passb_r",1'b0, 1'b0, 4'b0111, 64'h0,  64'h0,  64'h3,  64'h6C);
    step("passb_i",1'b0, 1'b1, 4'b0111, 64'h68, 64'h68, 64'h3,  64'h60);
    step("undef",  1'b0, 1'b0, 4'b1111, 64'h8,  64'h2,  64'hFF, 64'hFF);
    step("br_wrap",1'b0, 1'b0, 4'b0010, 64'hFFFF_FFFF_FFFF_FFFC, 64'h1, 64'h1, 64'h2);
    step("br_back",1'b0, 1'b1, 4'b0010, 64'h100, 64'hFFFF_FFFF_FFFF_FFFE, 64'h8, 64'h9);
    step("add_wr", 1'b0, 1'b0, 4'b0010, 64'h0, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h2);

    // Mid-stream reset with valid inputs applied, then release.
    step("reset_mid", 1'b1, 1'b0, 4'b0001, 64'h20, 64'h4, 64'hF0, 64'h0F);
    step("after_rst", 1'b0, 1'b0, 4'b0001, 64'h20, 64'h4, 64'hF0, 64'h0F);

    // Outputs must not follow inputs between edges.
    held = aluResult_E;
    readData1_E = 64'hDEAD; readData2_E = 64'hBEEF; AluControl = 4'b0010;
    #2;
    check("no_comb_path", aluResult_E, held);
    @(negedge clk);

    for (int i = 0; i < 40; i++) begin
      logic [3:0] ctl;
      logic [2:0] sel;
      sel = 3'($urandom_range(0, 5));
      case (sel)
        3'd0: ctl = 4'b0000; 3'd1: ctl = 4'b0001; 3'd2: ctl = 4'b0010;
        3'd3: ctl = 4'b0110; 3'd4: ctl = 4'b0111; default: ctl = 4'($urandom);
      endcase
      step("rand", 1'b0, 1'($urandom), ctl,
           {$urandom, $urandom}, {$urandom, $urandom},
           {$urandom, $urandom}, {$urandom, $urandom});
    end

    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule : tb_execute_stage
